tlul_console_sniffer: RTL and testbench

- Passive, synthesizable TL-UL snooper that reconstructs console text from software writes to the WDATA register of up to NUM_CH UART instances.
- Per-channel line buffers collect characters; completed lines are drained one at a time through a ready/valid byte stream tagged with channel ID.
- Also tracks A/D request balance on the snooped bus.
- Sits beside the host-side TL-UL port in simulation tops and FPGA debug builds; never drives the bus.

---
 rtl/tlul_console_sniffer.sv | 212 +++++++++++++++++++++
 tb/tb_tlul_console_sniffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_console_sniffer.sv
`default_nettype none
// ============================================================================
// Module      : tlul_console_sniffer
// Description : Passive TL-UL snooper. It rebuilds console lines from writes
//               to the UART WDATA registers, drains finished lines as a
//               channel-tagged byte stream and tracks A/D request balance.
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_console_sniffer #(
  parameter int          NUM_CH     = 2,
  parameter int          LINE_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter logic [31:0] CH_STRIDE  = 32'h0000_1000,
  parameter logic [31:0] WDATA_OFF  = 32'h0000_001c,
  parameter int          DROP_W     = 16,
  localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [31:0]       a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  input  logic              d_valid,
  input  logic              d_ready,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic [7:0]        outstanding_o,
  output logic              d_underflow_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int IDX_W = $clog2(LINE_DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] c_full_len = LEN_W'(LINE_DEPTH);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;

  ch_state_e         r_state [NUM_CH];
  logic [LEN_W-1:0]  r_len   [NUM_CH];
  logic [7:0]        r_buf   [NUM_CH][LINE_DEPTH];
  logic              r_busy;
  logic [CH_W-1:0]   r_drain_ch;
  logic [CH_W-1:0]   r_ptr;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [DROP_W-1:0] r_drop;
  logic [7:0]        r_outst;
  logic              r_underflow;

  logic              w_cap;
  logic [CH_W-1:0]   w_cap_ch;
  logic              w_cap_fill;
  logic              w_drop;
  logic [7:0]        w_char;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_accept;
  logic              w_last;
  logic              w_done;
  logic              w_grant;
  logic [CH_W-1:0]   w_grant_ch;
  logic [CH_W-1:0]   w_scan;
  logic              w_a_hs;
  logic              w_d_hs;

  // Only the low byte lane carries console text.
  logic w_unused_bits;
  assign w_unused_bits = ^{a_data[31:8], a_mask[3:1]};

  assign w_char     = a_data[7:0];
  assign w_cap_fill = w_cap && (r_state[w_cap_ch] == ST_FILL);
  assign w_drop     = w_cap && !w_cap_fill;
  assign w_wr_idx   = r_len[w_cap_ch][IDX_W-1:0];
  assign w_accept   = r_busy && out_ready;
  assign w_last     = ({1'b0, r_rd_idx} == (r_len[r_drain_ch] - LEN_W'(1)));
  assign w_done     = w_accept && w_last;
  assign w_a_hs     = a_valid && a_ready;
  assign w_d_hs     = d_valid && d_ready;

  // Decode a full/partial put of the low byte into one channel's WDATA.
  always_comb begin
    w_cap    = 1'b0;
    w_cap_ch = '0;
    if (w_a_hs && (a_opcode == 3'd0 || a_opcode == 3'd1) && a_mask[0]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (a_address == BASE_ADDR + CH_STRIDE * 32'(i) + WDATA_OFF) begin
          w_cap    = 1'b1;
          w_cap_ch = CH_W'(i);
        end
      end
    end
  end

  // Round-robin search for the next READY line, starting after the last grant;
  // a finishing drain frees the stream for a back-to-back grant.
  always_comb begin
    w_grant    = 1'b0;
    w_grant_ch = '0;
    w_scan     = '0;
    if (!r_busy || w_done) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        w_scan = CH_W'((int'(r_ptr) + k) % NUM_CH);
        if (!w_grant && r_state[w_scan] == ST_READY) begin
          w_grant    = 1'b1;
          w_grant_ch = w_scan;
        end
      end
    end
  end

  // Per-channel line state: fill, wait for the arbiter, drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= ST_FILL;
        r_len[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        case (r_state[c])
          ST_FILL: begin
            if (w_cap && w_cap_ch == CH_W'(c)) begin
              r_len[c] <= r_len[c] + LEN_W'(1);
              if (w_char == 8'h0A || (r_len[c] + LEN_W'(1)) == c_full_len || flush_i)
                r_state[c] <= ST_READY;
            end else if (flush_i && r_len[c] != '0) begin
              r_state[c] <= ST_READY;
            end
          end
          ST_READY: begin
            if (w_grant && w_grant_ch == CH_W'(c))
              r_state[c] <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (w_done) begin
              r_state[c] <= ST_FILL;
              r_len[c]   <= '0;
            end
          end
          default: r_state[c] <= ST_FILL;
        endcase
      end
    end
  end

  // Line storage; a channel only accepts characters while filling.
  always_ff @(posedge clk) begin
    if (w_cap_fill)
      r_buf[w_cap_ch][w_wr_idx] <= w_char;
  end

  // Drain sequencer: tracks the granted channel and read position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_drain_ch <= '0;
      r_rd_idx   <= '0;
      r_ptr      <= CH_W'(NUM_CH - 1);
    end else begin
      if (w_accept)
        r_rd_idx <= r_rd_idx + IDX_W'(1);
      if (w_done)
        r_busy <= 1'b0;
      if (w_grant) begin
        r_busy     <= 1'b1;
        r_drain_ch <= w_grant_ch;
        r_rd_idx   <= '0;
        r_ptr      <= w_grant_ch;
      end
    end
  end

  // Drop counter plus A/D balance tracking with sticky underflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop      <= '0;
      r_outst     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_drop && r_drop != '1)
        r_drop <= r_drop + DROP_W'(1);
      if (w_a_hs && !w_d_hs) begin
        if (r_outst != 8'hFF)
          r_outst <= r_outst + 8'd1;
      end else if (w_d_hs && !w_a_hs) begin
        if (r_outst == 8'd0)
          r_underflow <= 1'b1;
        else
          r_outst <= r_outst - 8'd1;
      end
    end
  end

  assign out_valid     = r_busy;
  assign out_data      = r_busy ? r_buf[r_drain_ch][r_rd_idx] : 8'h00;
  assign out_ch        = r_busy ? r_drain_ch : '0;
  assign out_last      = r_busy && w_last;
  assign outstanding_o = r_outst;
  assign d_underflow_o = r_underflow;
  assign drop_cnt_o    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_tlul_console_sniffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlul_console_sniffer
// Description : Self-checking bench for tlul_console_sniffer. A queue-based
//               line model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlul_console_sniffer;

  localparam int          NUM_CH     = 2;
  localparam int          LINE_DEPTH = 64;
  localparam logic [31:0] BASE_ADDR  = 32'h2000_0000;
  localparam logic [31:0] CH_STRIDE  = 32'h0000_1000;
  localparam logic [31:0] WDATA_OFF  = 32'h0000_001c;
  localparam int          DROP_W     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic        flush_i;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [0:0]  out_ch;
  logic        out_last;
  logic [7:0]  outstanding_o;
  logic        d_underflow_o;
  logic [DROP_W-1:0] drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 = collecting, 1 = complete and waiting, 2 = being output.
  int         m_phase [NUM_CH];
  logic [7:0] m_line  [NUM_CH][$];
  bit         m_busy;
  int         m_dch, m_pos, m_ptr, m_drop, m_outst;
  bit         m_uf;

  tlul_console_sniffer #(
    .NUM_CH(NUM_CH), .LINE_DEPTH(LINE_DEPTH), .BASE_ADDR(BASE_ADDR),
    .CH_STRIDE(CH_STRIDE), .WDATA_OFF(WDATA_OFF), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .outstanding_o(outstanding_o),
    .d_underflow_o(d_underflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] wdata_addr(input int ch);
    return BASE_ADDR + CH_STRIDE * 32'(ch) + WDATA_OFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_phase[i] = 0;
      m_line[i].delete();
    end
    m_busy = 0; m_dch = 0; m_pos = 0; m_ptr = NUM_CH - 1;
    m_drop = 0; m_outst = 0; m_uf = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_next();
    int  g, cc, idx;
    bit  done, ahs, dhs;
    done = m_busy && out_ready && (m_pos == m_line[m_dch].size() - 1);
    g = -1;
    if (!m_busy || done)
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = (m_ptr + k) % NUM_CH;
        if (g < 0 && m_phase[idx] == 1) g = idx;
      end
    cc = -1;
    if (a_valid && a_ready && (a_opcode == 3'd0 || a_opcode == 3'd1) && a_mask[0])
      for (int i = 0; i < NUM_CH; i++)
        if (a_address == wdata_addr(i)) cc = i;
    if (cc >= 0) begin
      if (m_phase[cc] == 0) begin
        m_line[cc].push_back(a_data[7:0]);
        if (a_data[7:0] == 8'h0A || m_line[cc].size() == LINE_DEPTH) m_phase[cc] = 1;
      end else if (m_drop < (1 << DROP_W) - 1) begin
        m_drop++;
      end
    end
    if (flush_i)
      for (int i = 0; i < NUM_CH; i++)
        if (m_phase[i] == 0 && m_line[i].size() > 0) m_phase[i] = 1;
    if (m_busy && out_ready) begin
      if (done) begin
        m_phase[m_dch] = 0;
        m_line[m_dch].delete();
        m_busy = 0;
      end else begin
        m_pos++;
      end
    end
    if (g >= 0) begin
      m_phase[g] = 2; m_busy = 1; m_dch = g; m_pos = 0; m_ptr = g;
    end
    ahs = a_valid && a_ready;
    dhs = d_valid && d_ready;
    if (ahs && !dhs && m_outst < 255) m_outst++;
    if (dhs && !ahs) begin
      if (m_outst == 0) m_uf = 1;
      else m_outst--;
    end
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, m_busy);
    if (m_busy) begin
      check("out_data", out_data, m_line[m_dch][m_pos]);
      check("out_ch", out_ch, m_dch);
      check("out_last", out_last, (m_pos == m_line[m_dch].size() - 1));
    end
    check("drop_cnt", drop_cnt_o, m_drop);
    check("outstanding", outstanding_o, m_outst);
    check("d_underflow", d_underflow_o, m_uf);
  endtask

  task automatic tick();
    if (!rst_n) model_reset();
    else model_next();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive_idle();
    a_valid = 0; a_ready = 0; a_opcode = 3'd0; a_address = 32'h0;
    a_mask = 4'h0; a_data = 32'h0; d_valid = 0; d_ready = 0; flush_i = 0;
  endtask

  task automatic idle(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put(input int ch, input logic [7:0] c);
    a_valid = 1; a_ready = 1; a_opcode = 3'd0; a_mask = 4'hF;
    a_address = wdata_addr(ch); a_data = {24'h0, c};
    tick();
    drive_idle();
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_last", out_last, 0);
    check("rst_outst", outstanding_o, 0);
    check("rst_uf", d_underflow_o, 0);
    check("rst_drop", drop_cnt_o, 0);
  endtask

  initial begin
    drive_idle();
    out_ready = 1;
    rst_n = 0;
    model_reset();
    tick(); tick();
    check_reset_outputs();
    rst_n = 1;
    tick();

    // A/D balance: 3 A, 2 D, 2 D (last one underflows).
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_ready = 1; a_opcode = 3'd4; a_address = 32'h0; tick();
    end
    drive_idle();
    check("outst_after_3a", outstanding_o, 3);
    for (int i = 0; i < 2; i++) begin d_valid = 1; d_ready = 1; tick(); end
    check("outst_after_2d", outstanding_o, 1);
    for (int i = 0; i < 2; i++) begin d_valid = 1; d_ready = 1; tick(); end
    drive_idle();
    check("outst_after_4d", outstanding_o, 0);
    check("underflow_set", d_underflow_o, 1);

    rst_n = 0; tick(); rst_n = 1; tick();

    // "Hi\n" on channel 0.
    put(0, 8'h48); put(0, 8'h69); put(0, 8'h0A);
    check("hi_lat_edge1", out_valid, 0);
    idle(1);
    check("hi_lat_edge2", out_valid, 1);
    check("hi_first", out_data, 8'h48);
    idle(6);

    // Move the pointer to ch1, then make both READY together via flush.
    put(1, 8'h7A); put(1, 8'h0A); idle(5);
    put(0, 8'h42); put(1, 8'h41);
    flush_i = 1; tick(); drive_idle();
    idle(8);

    // Stall the stream and overflow with captures to the draining channel.
    out_ready = 0;
    put(0, 8'h6B); put(0, 8'h0A); idle(2);
    put(0, 8'h78); put(0, 8'h79); put(0, 8'h7A);
    idle(3);
    check("drop_three", drop_cnt_o, 3);
    out_ready = 1;
    idle(5);

    // Full line of LINE_DEPTH characters, then one more in a fresh line.
    for (int i = 0; i < LINE_DEPTH; i++) put(0, 8'h61 + 8'(i % 26));
    idle(LINE_DEPTH + 6);
    put(0, 8'h51); put(0, 8'h0A); idle(6);

    // "ab" + flush, with a masked-out write and a Get to WDATA in between.
    put(0, 8'h61); put(0, 8'h62);
    a_valid = 1; a_ready = 1; a_opcode = 3'd0; a_mask = 4'hE;
    a_address = wdata_addr(0); a_data = 32'h58; tick();
    a_opcode = 3'd4; a_mask = 4'hF; a_data = 32'h59; tick();
    drive_idle();
    flush_i = 1; tick(); drive_idle();
    idle(6);

    // Saturate the outstanding counter, then unwind partially.
    for (int i = 0; i < 260; i++) begin
      a_valid = 1; a_ready = 1; a_opcode = 3'd4; a_address = 32'h0; tick();
    end
    drive_idle();
    check("outst_sat", outstanding_o, 255);
    for (int i = 0; i < 250; i++) begin d_valid = 1; d_ready = 1; tick(); end
    drive_idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      a_valid = ($urandom_range(0, 3) != 0);
      a_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      a_opcode = (r < 6) ? 3'd0 : (r < 8) ? 3'd1 : 3'd4;
      case ($urandom_range(0, 5))
        0, 1:    a_address = wdata_addr(0);
        2, 3:    a_address = wdata_addr(1);
        4:       a_address = wdata_addr(0) - 32'h4;
        default: a_address = wdata_addr(2);
      endcase
      a_mask = ($urandom_range(0, 7) == 0) ? 4'(($urandom_range(0, 7)) << 1) : 4'hF;
      a_data = $urandom;
      a_data[7:0] = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'(8'h41 + $urandom_range(0, 25));
      d_valid = ($urandom_range(0, 3) != 0);
      d_ready = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 31) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive_idle();
    out_ready = 1;
    idle(4);

    // Reset in the middle of a drain.
    out_ready = 0;
    put(1, 8'h72); put(1, 8'h0A); idle(2);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 0;
    tick();
    check_reset_outputs();
    rst_n = 1;
    out_ready = 1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
